// File: rtl/divisor_seq.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, followed by a single sign fix-up cycle.
module divisor_seq #(
  parameter int unsigned N = 8
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         END_DIV,
  output logic         DIV_ZERO,
  output logic         OVF
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  babs_q, babs_d;
  logic [N-1:0]  a_q, a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_a_q, neg_a_d;
  logic          sdiff_q, sdiff_d;
  logic          dz_q, dz_d;
  logic          ovf_lat_q, ovf_lat_d;

  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          end_q, end_d;
  logic          div_zero_q, div_zero_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  a_abs, b_abs;
  logic [N:0]    shifted, trial;

  // Magnitudes: -2^(N-1) negates to itself, which reads correctly as unsigned.
  always_comb begin
    a_abs = A[N-1] ? (-A) : A;
    b_abs = B[N-1] ? (-B) : B;
  end

  // Trial subtraction; bit N of the difference is the borrow.
  always_comb begin
    shifted = {rem_q, quo_q[N-1]};
    trial   = shifted - {1'b0, babs_q};
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    babs_d     = babs_q;
    a_d        = a_q;
    cnt_d      = cnt_q;
    neg_a_d    = neg_a_q;
    sdiff_d    = sdiff_q;
    dz_d       = dz_q;
    ovf_lat_d  = ovf_lat_q;
    q_d        = q_q;
    r_d        = r_q;
    end_d      = 1'b0;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d       = A;
          quo_d     = a_abs;
          babs_d    = b_abs;
          rem_d     = '0;
          cnt_d     = CW'(N - 1);
          neg_a_d   = A[N-1];
          sdiff_d   = A[N-1] ^ B[N-1];
          dz_d      = (B == '0);
          ovf_lat_d = (A == MIN_VAL) && (B == ALL_ONES);
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (!trial[N]) begin
          rem_d = trial[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        // Division by zero reports the dividend unchanged as the remainder.
        if (dz_q) begin
          q_d = '0;
          r_d = a_q;
        end else begin
          q_d = sdiff_q ? (-quo_q) : quo_q;
          r_d = neg_a_q ? (-rem_q) : rem_q;
        end
        div_zero_d = dz_q;
        ovf_d      = ovf_lat_q;
        end_d      = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      babs_q     <= '0;
      a_q        <= '0;
      cnt_q      <= '0;
      neg_a_q    <= 1'b0;
      sdiff_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_lat_q  <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      end_q      <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      babs_q     <= babs_d;
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      neg_a_q    <= neg_a_d;
      sdiff_q    <= sdiff_d;
      dz_q       <= dz_d;
      ovf_lat_q  <= ovf_lat_d;
      q_q        <= q_d;
      r_q        <= r_d;
      end_q      <= end_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign END_DIV  = end_q;
  assign DIV_ZERO = div_zero_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed-vector bench for divisor_seq at N=8 with hand-computed results.
module tb_divisor_seq;

  localparam int unsigned N = 8;
  // END_DIV is seen after N+1 edges following the accepting edge,
  // i.e. on the (N+2)th edge when the accepting edge is counted as the first.
  localparam int LAT = N + 1;

  logic         CLOCK;
  logic         RESET;
  logic         START;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         END_DIV;
  logic         DIV_ZERO;
  logic         OVF;

  int checks;
  int errors;
  int cyc;
  int acc_cyc;

  divisor_seq #(.N(N)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .START   (START),
    .A       (A),
    .B       (B),
    .Q       (Q),
    .R       (R),
    .END_DIV (END_DIV),
    .DIV_ZERO(DIV_ZERO),
    .OVF     (OVF)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge and return once the accepting edge passed.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
    @(negedge CLOCK);
    A     = a;
    B     = b;
    START = 1'b1;
    @(posedge CLOCK);
    #1;
    acc_cyc = cyc;
    if (!hold) START = 1'b0;
  endtask

  // Wait (bounded) for END_DIV; lat is edges since acceptance, -1 on timeout.
  task automatic wait_end(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLOCK);
      #1;
      if (END_DIV === 1'b1) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] eq, input logic [N-1:0] er,
                              input logic edz, input logic eovf);
    check({tag, "_q"},  32'(Q), 32'(eq));
    check({tag, "_r"},  32'(R), 32'(er));
    check({tag, "_dz"}, 32'(DIV_ZERO), 32'(edz));
    check({tag, "_ovf"}, 32'(OVF), 32'(eovf));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic edz, input logic eovf);
    int lat;
    start_op(a, b, 1'b0);
    wait_end(lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check_result(tag, eq, er, edz, eovf);
    @(posedge CLOCK);
    #1;
    check({tag, "_pulse"}, 32'(END_DIV), 32'(0));
  endtask

  initial begin
    int lat;
    int pulses;
    int c1;
    int c2;
    checks = 0;
    errors = 0;
    cyc    = 0;
    acc_cyc = 0;
    RESET  = 1'b1;
    START  = 1'b0;
    A      = '0;
    B      = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    check_result("rst", 8'h00, 8'h00, 1'b0, 1'b0);
    check("rst_end", 32'(END_DIV), 32'(0));
    @(negedge CLOCK);
    RESET = 1'b0;

    run_op("p100_7",   8'd100,  8'd7,    8'd14,   8'd2,    1'b0, 1'b0);
    run_op("m100_7",   8'h9C,   8'd7,    8'hF2,   8'hFE,   1'b0, 1'b0);
    run_op("p100_m7",  8'd100,  8'hF9,   8'hF2,   8'd2,    1'b0, 1'b0);
    run_op("m100_m7",  8'h9C,   8'hF9,   8'd14,   8'hFE,   1'b0, 1'b0);
    run_op("p3_5",     8'd3,    8'd5,    8'd0,    8'd3,    1'b0, 1'b0);
    run_op("ovf",      8'h80,   8'hFF,   8'h80,   8'h00,   1'b0, 1'b1);
    run_op("m128_1",   8'h80,   8'd1,    8'h80,   8'h00,   1'b0, 1'b0);
    run_op("p127_m128", 8'd127, 8'h80,   8'd0,    8'd127,  1'b0, 1'b0);
    run_op("zero_a",   8'd0,    8'd9,    8'd0,    8'd0,    1'b0, 1'b0);
    run_op("divz",     8'd55,   8'd0,    8'd0,    8'd55,   1'b1, 1'b0);

    // START re-pulsed with different operands while calculating.
    start_op(8'd100, 8'd7, 1'b0);
    repeat (2) @(negedge CLOCK);
    A = 8'd5;
    B = 8'd1;
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
    wait_end(lat);
    check("repulse_lat", 32'(lat), 32'(LAT));
    check_result("repulse", 8'd14, 8'd2, 1'b0, 1'b0);
    @(posedge CLOCK);

    // Asynchronous reset partway through CALC clears everything at once.
    start_op(8'd100, 8'd7, 1'b0);
    repeat (4) @(posedge CLOCK);
    #2;
    RESET = 1'b1;
    #1;
    check_result("arst", 8'h00, 8'h00, 1'b0, 1'b0);
    check("arst_end", 32'(END_DIV), 32'(0));
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLOCK);
      #1;
      if (END_DIV === 1'b1) pulses++;
    end
    check("arst_nopulse", 32'(pulses), 32'(0));
    run_op("m9_4", 8'hF7, 8'd4, 8'hFE, 8'hFF, 1'b0, 1'b0);

    // START held high: back-to-back operations.
    start_op(8'd20, 8'd3, 1'b1);
    A = 8'd50;
    B = 8'd6;
    wait_end(lat);
    c1 = cyc;
    check("b2b1_lat", 32'(lat), 32'(LAT));
    check_result("b2b1", 8'd6, 8'd2, 1'b0, 1'b0);
    repeat (2) @(posedge CLOCK);
    #1;
    acc_cyc = cyc;
    START = 1'b0;
    wait_end(lat);
    c2 = cyc;
    check("b2b_gap", 32'(c2 - c1), 32'(N + 3));
    check_result("b2b2", 8'd8, 8'd2, 1'b0, 1'b0);
    @(posedge CLOCK);
    #1;
    check("b2b2_pulse", 32'(END_DIV), 32'(0));

    repeat (3) @(posedge CLOCK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
